// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone read-DMA engine.
package wb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DRAIN,
    ST_FLUSH
  } dma_state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/dma_rd_fifo.sv
// Small synchronous FIFO for read data; head word is readable without a pop.
module dma_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/wb_dma_reader.sv
// Wishbone classic read-only DMA initiator: single-word reads into a FIFO,
// streamed out over valid/ready with tlast on the final word of each job.
module wb_dma_reader
  import wb_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             dma_cyc_o,
  output logic             dma_stb_o,
  output logic             dma_we_o,
  output logic [3:0]       dma_sel_o,
  output logic [31:0]      dma_adr_o,
  input  logic [31:0]      dma_dat_i,
  input  logic             dma_ack_i,
  output logic             m_tvalid,
  output logic [31:0]      m_tdata,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_t       state_reg;
  logic [31:0]      addr_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] issued_reg;
  logic [LEN_W-1:0] pop_idx_reg;
  logic [LEN_W-1:0] pop_idx_next;
  logic             stb_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             aborted_reg;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clear;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             job_finished;

  // Data from an ack that coincides with a pending abort is dropped.
  assign fifo_push  = (state_reg == ST_REQ) && dma_ack_i && !abort;
  assign fifo_clear = (state_reg == ST_FLUSH);
  assign m_tvalid   = !fifo_empty && !fifo_clear;
  assign fifo_pop   = m_tvalid && m_tready;

  assign pop_idx_next = pop_idx_reg + LEN_W'(fifo_pop);
  assign m_tlast      = m_tvalid && (pop_idx_reg == len_reg - LEN_W'(1));

  // Finished once every word is issued and the final word leaves this cycle.
  assign job_finished = (issued_reg == len_reg) && (pop_idx_next == len_reg) &&
                        (fifo_count == CNT_W'(fifo_pop));

  dma_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (fifo_clear),
    .din   (dma_dat_i),
    .dout  (m_tdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      len_reg     <= '0;
      issued_reg  <= '0;
      pop_idx_reg <= '0;
      stb_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (fifo_pop) pop_idx_reg <= pop_idx_next;

      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          if (cmd_valid) begin
            addr_reg    <= cmd_addr & ~32'h3;
            len_reg     <= cmd_len;
            issued_reg  <= '0;
            pop_idx_reg <= '0;
            aborted_reg <= 1'b0;
            busy_reg    <= 1'b1;
            if (cmd_len == '0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          if (abort) begin
            state_reg <= ST_FLUSH;
          end else if ((issued_reg < len_reg) && !fifo_full) begin
            state_reg <= ST_REQ;
            stb_reg   <= 1'b1;
          end else if (job_finished) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end

        // The strobe is never withdrawn mid-cycle; abort waits for the ack.
        ST_REQ: begin
          if (dma_ack_i) begin
            stb_reg <= 1'b0;
            if (abort) begin
              state_reg <= ST_FLUSH;
            end else begin
              addr_reg   <= addr_reg + ADDR_STEP;
              issued_reg <= issued_reg + LEN_W'(1);
              state_reg  <= ST_GAP;
            end
          end else if (abort) begin
            state_reg <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (dma_ack_i) begin
            stb_reg   <= 1'b0;
            state_reg <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          state_reg   <= ST_IDLE;
          done_reg    <= 1'b1;
          aborted_reg <= 1'b1;
        end

        default: begin
          state_reg <= ST_IDLE;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign dma_cyc_o = stb_reg;
  assign dma_stb_o = stb_reg;
  assign dma_we_o  = 1'b0;
  assign dma_sel_o = WB_SEL_ALL;
  assign dma_adr_o = addr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign aborted   = aborted_reg;

endmodule

// File: tb/tb_wb_dma_reader.sv
// Randomized scoreboard bench for wb_dma_reader against a word-addressed memory model.
module tb_wb_dma_reader;

  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             abort = 1'b0;
  logic             dma_cyc_o, dma_stb_o, dma_we_o;
  logic [3:0]       dma_sel_o;
  logic [31:0]      dma_adr_o;
  logic [31:0]      dma_dat_i = '0;
  logic             dma_ack_i = 1'b0;
  logic             m_tvalid;
  logic [31:0]      m_tdata;
  logic             m_tlast;
  logic             m_tready = 1'b0;
  logic             busy, done, aborted;

  wb_dma_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .abort    (abort),
    .dma_cyc_o(dma_cyc_o), .dma_stb_o(dma_stb_o), .dma_we_o(dma_we_o), .dma_sel_o(dma_sel_o),
    .dma_adr_o(dma_adr_o), .dma_dat_i(dma_dat_i), .dma_ack_i(dma_ack_i),
    .m_tvalid (m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy     (busy), .done(done), .aborted(aborted)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_cnt = 0;
  int ack_cnt = 0, stream_cnt = 0, done_cnt = 0, stb_cycles = 0;
  int last_hs_cyc = 0, done_cyc = 0;
  int ready_mode = 1;  // 0: stalled, 1: always ready, 2: random
  int job_done_base, job_ack_base, job_stream_base;

  logic [31:0] exp_addr_q[$];
  logic [32:0] exp_word_q[$];

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Memory slave: random 0..3 wait states, data is a pure function of address.
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    forever begin
      tick();
      if (dma_stb_o && !wb_rst_i) begin
        if (lat_cnt == 0) begin
          dma_ack_i = 1'b1;
          dma_dat_i = mem_word(dma_adr_o);
          lat_cnt = $urandom_range(0, 3);
        end else begin
          lat_cnt--;
          dma_ack_i = 1'b0;
          dma_dat_i = $urandom;
        end
      end else begin
        dma_ack_i = 1'b0;
        dma_dat_i = $urandom;
      end
    end
  end

  initial begin
    forever begin
      tick();
      m_tready = (ready_mode == 0) ? 1'b0 :
                 (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Bus monitor: protocol rules plus expected read addresses.
  initial begin
    logic prev_stb, prev_ack;
    logic [31:0] prev_adr;
    prev_stb = 1'b0; prev_ack = 1'b0; prev_adr = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        prev_stb = 1'b0; prev_ack = 1'b0;
      end else begin
        if (dma_stb_o) stb_cycles++;
        if (prev_ack) check("stb_gap_after_ack", 32'(dma_stb_o), 32'd0);
        if (prev_stb && !prev_ack) begin
          check("stb_held_until_ack", 32'(dma_stb_o), 32'd1);
          check("adr_stable", dma_adr_o, prev_adr);
        end
        if (dma_stb_o && dma_ack_i) begin
          ack_cnt++;
          check("cyc_eq_stb", 32'(dma_cyc_o), 32'(dma_stb_o));
          check("we_sel", {27'd0, dma_we_o, dma_sel_o}, 32'h0000_000F);
          if (exp_addr_q.size() == 0) fail_now("unexpected_read");
          else check("read_adr", dma_adr_o, exp_addr_q.pop_front());
        end
        prev_stb = dma_stb_o; prev_ack = dma_ack_i; prev_adr = dma_adr_o;
      end
    end
  end

  // Stream monitor: in-order data and tlast against the scoreboard.
  initial begin
    logic [32:0] w;
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i && m_tvalid && m_tready) begin
        stream_cnt++;
        if (m_tlast) last_hs_cyc = cyc_cnt;
        if (exp_word_q.size() == 0) begin
          fail_now("unexpected_stream_word");
        end else begin
          w = exp_word_q.pop_front();
          check("tdata", m_tdata, w[31:0]);
          check("tlast", 32'(m_tlast), 32'(w[32]));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i && done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
        check("busy_at_done", 32'(busy), 32'd1);
        check("ready_at_done", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic start_job(input logic [31:0] a, input int len);
    logic [31:0] base;
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 200) begin tick(); waited++; end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    base = a & ~32'h3;
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(base + 32'(4 * i));
      exp_word_q.push_back({(i == len - 1), mem_word(base + 32'(4 * i))});
    end
    job_done_base = done_cnt; job_ack_base = ack_cnt; job_stream_base = stream_cnt;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = LEN_W'(len);
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = LEN_W'($urandom);
    check("aborted_cleared_on_accept", 32'(aborted), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (len == 0) begin
      check("zero_len_done_next", 32'(done), 32'd1);
    end else begin
      check("stb_low_in_gap", 32'(dma_stb_o), 32'd0);
      tick();
      check("stb_at_n_plus_2", 32'(dma_stb_o), 32'd1);
    end
  endtask

  task automatic wait_done();
    int waited;
    waited = 0;
    while (done_cnt == job_done_base && waited < 3000) begin tick(); waited++; end
    if (done_cnt == job_done_base) fail_now("done_timeout");
  endtask

  task automatic finish_job(input int len, input bit was_abort);
    wait_done();
    repeat (3) tick();
    check("done_pulse_count", 32'(done_cnt - job_done_base), 32'd1);
    check("busy_cleared", 32'(busy), 32'd0);
    check("aborted_flag", 32'(aborted), 32'(was_abort));
    if (was_abort) begin
      check("abort_drops_acked_word",
            32'((stream_cnt - job_stream_base) < (ack_cnt - job_ack_base)), 32'd1);
      exp_addr_q.delete();
      exp_word_q.delete();
    end else begin
      check("reads_issued", 32'(ack_cnt - job_ack_base), 32'(len));
      check("words_streamed", 32'(stream_cnt - job_stream_base), 32'(len));
      check("scoreboard_empty", 32'(exp_word_q.size() + exp_addr_q.size()), 32'd0);
      if (len > 0) check("done_after_tlast", 32'(done_cyc - last_hs_cyc), 32'd1);
    end
    $display("[TB] job len=%0d reads=%0d words=%0d aborted=%0b", len,
             ack_cnt - job_ack_base, stream_cnt - job_stream_base, aborted);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a0, waited;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("rst_stb_cyc", {30'd0, dma_stb_o, dma_cyc_o}, 32'd0);
    check("rst_adr", dma_adr_o, 32'd0);
    check("rst_stream", {30'd0, m_tvalid, m_tlast}, 32'd0);
    check("rst_status", {29'd0, busy, done, aborted}, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    wb_rst_i = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    ready_mode = 1;
    start_job(32'h3800_0010, 3);
    finish_job(3, 1'b0);

    s = stb_cycles;
    start_job(32'h1111_2220, 0);
    finish_job(0, 1'b0);
    check("zero_len_no_stb", 32'(stb_cycles - s), 32'd0);

    ready_mode = 0;
    start_job(32'h2000_0100, 8);
    repeat (60) tick();
    check("backpressure_reads", 32'(ack_cnt - job_ack_base), 32'(FIFO_DEPTH));
    check("backpressure_bus_idle", 32'(dma_stb_o), 32'd0);
    check("backpressure_tvalid", 32'(m_tvalid), 32'd1);
    ready_mode = 1;
    finish_job(8, 1'b0);

    ready_mode = 2;
    start_job(32'h4000_0000, 10);
    waited = 0;
    while (!(dma_stb_o && (ack_cnt - job_ack_base) >= 2) && waited < 500) begin tick(); waited++; end
    if (!dma_stb_o) fail_now("abort_setup_timeout");
    a0 = ack_cnt;
    abort = 1'b1;
    wait_done();
    abort = 1'b0;
    check("abort_single_pending_ack", 32'(ack_cnt - a0), 32'd1);
    finish_job(10, 1'b1);

    start_job(32'h5000_0004, 2);
    finish_job(2, 1'b0);

    start_job(32'hFFFF_FFFC, 2);
    finish_job(2, 1'b0);

    start_job(32'h1234_5677, 5);
    finish_job(5, 1'b0);

    for (int j = 0; j < 6; j++) begin
      int len;
      len = $urandom_range(1, 12);
      start_job($urandom, len);
      finish_job(len, 1'b0);
    end

    start_job(32'h6000_0000, 6);
    waited = 0;
    while (!dma_stb_o && waited < 100) begin tick(); waited++; end
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_stb", {30'd0, dma_stb_o, dma_cyc_o}, 32'd0);
    check("mid_rst_stream_busy", {30'd0, m_tvalid, busy}, 32'd0);
    tick();
    wb_rst_i = 1'b0;
    exp_addr_q.delete();
    exp_word_q.delete();
    tick();
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    start_job(32'h7000_0040, 4);
    finish_job(4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_dma_reader.md
# wb_dma_reader

Wishbone classic initiator that executes read-only DMA jobs: on a command (start address, word count) it issues single-word Wishbone reads toward the CPU/DMA arbiter port, buffers returned data in a small FIFO, and streams it out on a valid/ready interface. It is the master side that drives the arbiter's DMA request lines into the SDRAM-backed user memory. Command and status are direct ports; a CSR wrapper is a separate block.

## Interface
Parameters:
- FIFO_DEPTH, 4 — read-data buffer depth in words; power of two, ≥2
- LEN_W, 16 — width of word-count field

Ports:
- wb_clk_i  in  1  clock; single clock domain
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  32  byte start address; bits [1:0] ignored (forced 0)
- cmd_len  in  LEN_W  number of 32-bit words
- abort  in  1  level; stop current job
- dma_cyc_o, dma_stb_o  out  1  Wishbone cycle/strobe, always driven equal
- dma_we_o  out  1  constant 0
- dma_sel_o  out  4  constant 4'hF
- dma_adr_o  out  32  word-aligned byte address
- dma_dat_i  in  32  read data
- dma_ack_i  in  1  transfer acknowledge
- m_tvalid  out  1  stream data valid
- m_tdata  out  32  stream data
- m_tlast  out  1  last word of job
- m_tready  in  1  stream sink ready
- busy  out  1  job active
- done  out  1  one-cycle pulse at job end
- aborted  out  1  sticky; set when job ended by abort, cleared on next command accept

## Operation
- States: IDLE, REQ, GAP, DRAIN, FLUSH.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches addr (low bits zeroed), remaining=cmd_len, issued=0. If cmd_len==0 → done pulse next cycle, stay IDLE, no bus activity. Else → GAP.
- GAP: stb/cyc low. If abort → FLUSH. Else if issued<len and fifo_count < FIFO_DEPTH → REQ. Else if all words issued and FIFO empty and last word accepted → IDLE with done.
- REQ: cyc=stb=1, adr=current address; held stable until ack. On ack: write dma_dat_i to FIFO, addr += 4 (mod 2^32, wraps silently), issued++, → GAP. abort during REQ is not honoured until ack (no mid-cycle drop) → then DRAIN path: data of that ack is discarded, → FLUSH.
- FLUSH: FIFO cleared in one cycle, m_tvalid low; → IDLE, done pulse, aborted=1.
- DRAIN is the REQ-with-abort-pending substate: stb held until ack, then → FLUSH.
- Stream: m_tvalid = FIFO non-empty; m_tdata = FIFO head; pop on m_tvalid&m_tready. m_tlast=1 on the head word whose sequence index == len-1.
- busy=1 from the cycle after command accept until the done cycle inclusive.
- Simultaneous FIFO push (ack) and pop in same cycle permitted; count unchanged.

## Timing
- Reset values: cyc/stb 0, adr 0, m_tvalid 0, m_tlast 0, busy 0, done 0, aborted 0, cmd_ready 1, FIFO empty, state IDLE.
- Accept at edge N → stb high from cycle N+2 (one GAP cycle).
- stb deasserts the cycle after ack and stays low ≥1 cycle between transfers (required by the SDRAM path's read-valid tracking). Best-case throughput 1 word per (ack latency + 1) cycles.
- Data acked at edge K is visible on m_tdata/m_tvalid from cycle K+1.
- done pulses the cycle after the tlast handshake; cmd_ready high the same cycle.
- Sink stalled with FIFO full: no new REQ; bus stays idle.
- Reset mid-transfer: cyc/stb drop immediately, FIFO and counters cleared.

## Structure
- Package wb_dma_pkg: state enum, WB_SEL_ALL=4'hF, ADDR_STEP=4.
- Sub-module dma_rd_fifo: synchronous FIFO (push, pop, clear, count, full, empty) parameterised by depth/width; main FSM, address/issue counters in wb_dma_reader.

## Test plan
- Reset: all outputs at reset values; cmd_ready=1.
- Basic: addr=0x3800_0010, len=3, ack 2 cycles after stb, m_tready=1 → reads at 0x...10, 0x...14, 0x...18; tdata matches; tlast on 3rd; one done pulse; stb low ≥1 cycle between.
- Backpressure: len=8, FIFO_DEPTH=4, m_tready=0 → exactly 4 reads issued then bus idle; release ready → remaining 4 read, order preserved.
- Zero length: len=0 → done next cycle, no stb ever, aborted=0.
- Abort mid-REQ: len=10, abort while stb high → stb held until ack, acked data not streamed, FIFO flushed, done pulse, aborted=1; next command clears aborted.
- Wrap: addr=0xFFFF_FFFC, len=2 → adr 0xFFFF_FFFC then 0x0000_0000.
